// File: rtl/branch_predictor.sv
// Fetch-side predictor: direct-mapped BTB with per-entry 2-bit saturating counters.
// Latency: prediction 1 cycle after req; update written 1 cycle after upd_en, forwarded to lookup meanwhile.
// Backpressure: stall holds pred_*; updates are never blocked and never stall fetch.
module branch_predictor #(
    parameter int INDEX_W = 6,
    parameter int TAG_W   = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic [31:0] req_pc,
    input  logic        stall,
    input  logic        flush,
    output logic        pred_valid,
    output logic [31:0] pred_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_en,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target
);
    localparam int ENTRIES = 1 << INDEX_W;

    typedef struct packed {
        logic             vld;
        logic [TAG_W-1:0] tag;
        logic [1:0]       ctr;
        logic [31:0]      target;
    } entry_t;

    logic [ENTRIES-1:0] ent_vld;
    logic [1:0]         ent_ctr [ENTRIES];
    logic [TAG_W-1:0]   ent_tag [ENTRIES];
    logic [31:0]        ent_tgt [ENTRIES];

    // Pending slot holds the already-resolved post-write entry value.
    logic               pend_we;
    logic [INDEX_W-1:0] pend_idx;
    entry_t             pend_ent;

    logic [INDEX_W-1:0] req_idx, upd_idx;
    logic [TAG_W-1:0]   req_tag, upd_tag;
    entry_t             lk_ent, up_ent, nxt_ent;
    logic               lk_taken, up_hit, nxt_we;
    logic [31:0]        lk_target;
    logic               upd_pc_unused;

    assign req_idx       = req_pc[INDEX_W+1:2];
    assign req_tag       = req_pc[31:32-TAG_W];
    assign upd_idx       = upd_pc[INDEX_W+1:2];
    assign upd_tag       = upd_pc[31:32-TAG_W];
    assign upd_pc_unused = ^upd_pc[1:0];

    function automatic entry_t read_entry(input logic [INDEX_W-1:0] idx);
        entry_t e;
        if (pend_we && pend_idx == idx) begin
            e = pend_ent;
        end else begin
            e.vld    = ent_vld[idx];
            e.tag    = ent_tag[idx];
            e.ctr    = ent_ctr[idx];
            e.target = ent_tgt[idx];
        end
        return e;
    endfunction

    always_comb begin
        lk_ent    = read_entry(req_idx);
        lk_taken  = lk_ent.vld && (lk_ent.tag == req_tag) && lk_ent.ctr[1];
        lk_target = lk_taken ? lk_ent.target : req_pc + 32'd4;
    end

    always_comb begin
        up_ent  = read_entry(upd_idx);
        up_hit  = up_ent.vld && (up_ent.tag == upd_tag);
        nxt_ent = up_ent;
        nxt_we  = 1'b0;
        if (upd_en) begin
            if (up_hit) begin
                nxt_we = 1'b1;
                if (upd_taken) begin
                    if (up_ent.ctr != 2'b11) nxt_ent.ctr = up_ent.ctr + 2'd1;
                    nxt_ent.target = upd_target;
                end else if (up_ent.ctr != 2'b00) begin
                    nxt_ent.ctr = up_ent.ctr - 2'd1;
                end
            end else if (upd_taken) begin
                nxt_we         = 1'b1;
                nxt_ent.vld    = 1'b1;
                nxt_ent.tag    = upd_tag;
                nxt_ent.ctr    = 2'b10;
                nxt_ent.target = upd_target;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_we  <= 1'b0;
            pend_idx <= '0;
            pend_ent <= '0;
        end else begin
            pend_we <= nxt_we;
            if (nxt_we) begin
                pend_idx <= upd_idx;
                pend_ent <= nxt_ent;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_vld <= '0;
            for (int i = 0; i < ENTRIES; i++) ent_ctr[i] <= 2'b01;
        end else if (pend_we) begin
            ent_vld[pend_idx] <= pend_ent.vld;
            ent_ctr[pend_idx] <= pend_ent.ctr;
        end
    end

    // Tag/target are qualified by the valid bit, so they need no reset.
    always_ff @(posedge clk) begin
        if (pend_we) begin
            ent_tag[pend_idx] <= pend_ent.tag;
            ent_tgt[pend_idx] <= pend_ent.target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_valid  <= 1'b0;
            pred_pc     <= '0;
            pred_taken  <= 1'b0;
            pred_target <= '0;
        end else if (flush) begin
            pred_valid <= 1'b0;
        end else if (!stall) begin
            pred_valid <= req_valid;
            if (req_valid) begin
                pred_pc     <= req_pc;
                pred_taken  <= lk_taken;
                pred_target <= lk_target;
            end
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Randomized + directed bench for branch_predictor against a serial table model.
module tb_branch_predictor;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, stall = 1'b0, flush = 1'b0;
    logic [31:0] req_pc = '0;
    logic        upd_en = 1'b0, upd_taken = 1'b0;
    logic [31:0] upd_pc = '0, upd_target = '0;
    logic        pred_valid, pred_taken;
    logic [31:0] pred_pc, pred_target;

    always #5 clk = ~clk;

    branch_predictor dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_pc(req_pc), .stall(stall), .flush(flush),
        .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Model: tables updated serially; an update affects lookups from the next cycle on.
    bit          m_vld [64];
    bit [23:0]   m_tag [64];
    int          m_ctr [64];
    bit [31:0]   m_tgt [64];
    bit          e_valid, e_taken;
    bit [31:0]   e_pc, e_tgt;

    initial begin
        bit [5:0]  i;
        bit [23:0] t;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int k = 0; k < 64; k++) begin
                    m_vld[k] = 1'b0;
                    m_ctr[k] = 1;
                end
                e_valid = 1'b0; e_taken = 1'b0; e_pc = '0; e_tgt = '0;
            end else begin
                if (flush) begin
                    e_valid = 1'b0;
                end else if (!stall) begin
                    e_valid = req_valid;
                    if (req_valid) begin
                        i = req_pc[7:2];
                        t = req_pc[31:8];
                        e_pc    = req_pc;
                        e_taken = m_vld[i] && m_tag[i] == t && m_ctr[i] >= 2;
                        e_tgt   = e_taken ? m_tgt[i] : req_pc + 32'd4;
                    end
                end
                if (upd_en) begin
                    i = upd_pc[7:2];
                    t = upd_pc[31:8];
                    if (m_vld[i] && m_tag[i] == t) begin
                        if (upd_taken) begin
                            m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
                            m_tgt[i] = upd_target;
                        end else begin
                            m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
                        end
                    end else if (upd_taken) begin
                        m_vld[i] = 1'b1;
                        m_tag[i] = t;
                        m_ctr[i] = 2;
                        m_tgt[i] = upd_target;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("model_valid", {31'd0, pred_valid}, {31'd0, e_valid});
                if (e_valid) begin
                    chk("model_pc", pred_pc, e_pc);
                    chk("model_taken", {31'd0, pred_taken}, {31'd0, e_taken});
                    chk("model_target", pred_target, e_tgt);
                end
            end
        end
    end

    task automatic idle();
        req_valid = 1'b0; upd_en = 1'b0; stall = 1'b0; flush = 1'b0;
    endtask
    task automatic step();
        @(negedge clk);
    endtask
    task automatic req(input logic [31:0] pc);
        req_valid = 1'b1; req_pc = pc;
    endtask
    task automatic upd(input logic [31:0] pc, input logic t, input logic [31:0] tgt);
        upd_en = 1'b1; upd_pc = pc; upd_taken = t; upd_target = tgt;
    endtask
    task automatic chk_pred(input string name, input logic tk, input logic [31:0] tgt);
        chk({name, "_valid"}, {31'd0, pred_valid}, 32'd1);
        chk({name, "_taken"}, {31'd0, pred_taken}, {31'd0, tk});
        chk({name, "_target"}, pred_target, tgt);
    endtask

    function automatic logic [31:0] rand_pc();
        logic [23:0] tag;
        logic [5:0]  idx;
        logic [1:0]  low;
        tag = ($urandom_range(0, 1) == 0) ? 24'h1C0000 : 24'h1C0010;
        idx = 6'($urandom_range(0, 7));
        low = 2'($urandom_range(0, 3));
        return {tag, idx, low};
    endfunction

    initial begin
        repeat (2) step();
        chk("reset_valid", {31'd0, pred_valid}, 32'd0);
        chk("reset_taken", {31'd0, pred_taken}, 32'd0);
        chk("reset_pc", pred_pc, 32'd0);
        chk("reset_target", pred_target, 32'd0);
        rst_n = 1'b1;
        step();

        idle(); req(32'h1C000000); step();
        chk_pred("cold_miss", 1'b0, 32'h1C000004);

        idle(); upd(32'h1C000010, 1'b1, 32'h1C000100); step();
        idle(); step(); step();
        req(32'h1C000010); step();
        chk_pred("alloc_hit", 1'b1, 32'h1C000100);

        for (int k = 0; k < 3; k++) begin idle(); upd(32'h1C000020, 1'b1, 32'h1C000200); step(); end
        for (int k = 0; k < 2; k++) begin idle(); upd(32'h1C000020, 1'b0, 32'h0); step(); end
        idle(); req(32'h1C000020); step();
        chk_pred("sat_down", 1'b0, 32'h1C000024);
        idle(); upd(32'h1C000020, 1'b1, 32'h1C000300); step();
        idle(); req(32'h1C000020); step();
        chk_pred("sat_up", 1'b1, 32'h1C000300);

        idle(); upd(32'h1C000030, 1'b1, 32'h1C000400); step();
        idle(); step();
        idle(); upd(32'h1C000030, 1'b1, 32'h1C000500); step();
        idle(); upd(32'h1C000030, 1'b0, 32'h0); step();
        idle(); req(32'h1C000030); step();
        chk_pred("b2b_fwd", 1'b1, 32'h1C000500);

        idle(); req(32'h1C001010); step();
        chk_pred("alias_miss", 1'b0, 32'h1C001014);
        idle(); upd(32'h1C001010, 1'b1, 32'h1C002000); step();
        idle(); step();
        idle(); req(32'h1C000010); step();
        chk_pred("alias_evict", 1'b0, 32'h1C000014);
        idle(); req(32'h1C001010); step();
        chk_pred("alias_new", 1'b1, 32'h1C002000);

        idle(); req(32'h1C000010); step();
        for (int k = 0; k < 3; k++) begin
            idle(); stall = 1'b1; req(32'h1C000100 + 32'(k * 4)); step();
            chk("stall_pc", pred_pc, 32'h1C000010);
            chk("stall_valid", {31'd0, pred_valid}, 32'd1);
        end
        idle(); stall = 1'b1; flush = 1'b1; req(32'h1C000050); step();
        chk("flush_valid", {31'd0, pred_valid}, 32'd0);

        idle(); req(32'h1C000040); upd(32'h1C000040, 1'b1, 32'h1C000600);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, pred_valid}, 32'd0);
        chk("midrst_taken", {31'd0, pred_taken}, 32'd0);
        chk("midrst_pc", pred_pc, 32'd0);
        chk("midrst_target", pred_target, 32'd0);
        idle(); step(); step();
        rst_n = 1'b1;
        step();
        idle(); req(32'h1C000040); step();
        chk_pred("midrst_lost", 1'b0, 32'h1C000044);

        repeat (3000) begin
            idle();
            req_valid  = ($urandom_range(0, 9) < 8);
            req_pc     = rand_pc();
            stall      = ($urandom_range(0, 9) == 0);
            flush      = ($urandom_range(0, 19) == 0);
            upd_en     = ($urandom_range(0, 2) == 0);
            upd_pc     = rand_pc();
            upd_taken  = ($urandom_range(0, 2) != 0);
            upd_target = $urandom;
            step();
        end

        idle(); step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
